pipeline_hazard_ctrl: RTL and testbench

Central hazard controller for the 5-stage MIPS pipeline. It drives the per-stage write enables and flush strobes of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers, and the PC write enable.
- Detects load-use hazards and taken branches/jumps.
- Tracks the multi-cycle mult/div unit so HI/LO consumers are held in ID.
- Keeps a saturating stall-cycle counter for performance debug.

---
 rtl/pipeline_pkg.sv | 34 +++
 rtl/md_busy_tracker.sv | 70 +++++++
 rtl/pipeline_hazard_ctrl.sv | 100 ++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// Shared types and constants for the pipeline hazard controller and its mult/div tracker.
// Pure declarations: no latency, no flow control.
package pipeline_pkg;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } md_state_e;

  localparam int MUL_CYCLES_DEF = 4;
  localparam int DIV_CYCLES_DEF = 32;

  localparam logic [4:0] REG_ZERO = 5'd0;

  // Front-end stage controls that the priority mux selects between.
  typedef struct packed {
    logic pc_wr;
    logic if_id_wr;
    logic id_ex_wr;
    logic if_id_flush;
    logic id_ex_flush;
  } hz_ctrl_t;

  localparam hz_ctrl_t CTRL_RESET  = '{pc_wr: 1'b0, if_id_wr: 1'b0, id_ex_wr: 1'b0, if_id_flush: 1'b1, id_ex_flush: 1'b1};
  localparam hz_ctrl_t CTRL_RUN    = '{pc_wr: 1'b1, if_id_wr: 1'b1, id_ex_wr: 1'b1, if_id_flush: 1'b0, id_ex_flush: 1'b0};
  localparam hz_ctrl_t CTRL_STALL  = '{pc_wr: 1'b0, if_id_wr: 1'b0, id_ex_wr: 1'b1, if_id_flush: 1'b0, id_ex_flush: 1'b1};
  localparam hz_ctrl_t CTRL_BRANCH = '{pc_wr: 1'b1, if_id_wr: 1'b1, id_ex_wr: 1'b1, if_id_flush: 1'b1, id_ex_flush: 1'b1};
  localparam hz_ctrl_t CTRL_JUMP   = '{pc_wr: 1'b1, if_id_wr: 1'b1, id_ex_wr: 1'b1, if_id_flush: 1'b1, id_ex_flush: 1'b0};

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/md_busy_tracker.sv
// Occupancy tracker for the multi-cycle mult/div unit: busy for N cycles starting the cycle after start.
// Starts arriving while busy are dropped and latched into a sticky error flag.
module md_busy_tracker
  import pipeline_pkg::*;
#(
  parameter int MUL_CYCLES = MUL_CYCLES_DEF,
  parameter int DIV_CYCLES = DIV_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic md_start,
  input  logic md_is_div,
  output logic md_busy,
  output logic md_done,
  output logic md_err
);

  localparam int MAX_CYCLES = max_int(MUL_CYCLES, DIV_CYCLES);
  localparam int CW         = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

  localparam logic [CW-1:0] MUL_LOAD = CW'(MUL_CYCLES - 1);
  localparam logic [CW-1:0] DIV_LOAD = CW'(DIV_CYCLES - 1);

  md_state_e     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    case (state_q)
      MD_IDLE: begin
        if (md_start) begin
          cnt_d   = md_is_div ? DIV_LOAD : MUL_LOAD;
          state_d = MD_BUSY;
        end
      end
      MD_BUSY: begin
        // A second issue cannot be accepted; the running count is left intact.
        if (md_start) begin
          err_d = 1'b1;
        end
        if (cnt_q == '0) begin
          state_d = MD_IDLE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = MD_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= MD_IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign md_busy = rst & (state_q == MD_BUSY);
  assign md_done = md_busy & (cnt_q == '0);
  assign md_err  = err_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard controller for the 5-stage pipeline: combinational stage enables/flushes from load-use, HI/LO and redirect terms.
// Stalls hold PC and IF/ID while a bubble enters EX; a taken branch overrides any stall.
module pipeline_hazard_ctrl
  import pipeline_pkg::*;
#(
  parameter int MUL_CYCLES = MUL_CYCLES_DEF,
  parameter int DIV_CYCLES = DIV_CYCLES_DEF,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic             id_uses_hilo,
  input  logic             id_jump,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_rd,
  input  logic             ex_branch_taken,
  input  logic             ex_md_start,
  input  logic             ex_md_is_div,
  output logic             pc_wr,
  output logic             if_id_wr,
  output logic             id_ex_wr,
  output logic             ex_mem_wr,
  output logic             mem_wb_wr,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             md_busy,
  output logic             md_done,
  output logic             md_err,
  output logic [CNT_W-1:0] stall_count
);

  logic             load_use;
  logic             hilo_stall;
  logic             stall;
  hz_ctrl_t         ctrl;
  logic [CNT_W-1:0] stall_count_q, stall_count_d;

  md_busy_tracker #(
    .MUL_CYCLES (MUL_CYCLES),
    .DIV_CYCLES (DIV_CYCLES)
  ) u_md (
    .clk       (clk),
    .rst       (rst),
    .md_start  (ex_md_start),
    .md_is_div (ex_md_is_div),
    .md_busy   (md_busy),
    .md_done   (md_done),
    .md_err    (md_err)
  );

  // $zero is never a real producer, so a load targeting it cannot create a dependency.
  assign load_use = ex_mem_read & (ex_rd != REG_ZERO) &
                    ((id_uses_rs & (id_rs == ex_rd)) | (id_uses_rt & (id_rt == ex_rd)));
  assign hilo_stall = md_busy & id_uses_hilo;
  assign stall      = load_use | hilo_stall;

  always_comb begin
    ctrl = CTRL_RUN;
    if (!rst) begin
      ctrl = CTRL_RESET;
    end else if (ex_branch_taken) begin
      ctrl = CTRL_BRANCH;
    end else if (stall) begin
      ctrl = CTRL_STALL;
    end else if (id_jump) begin
      ctrl = CTRL_JUMP;
    end
  end

  assign pc_wr       = ctrl.pc_wr;
  assign if_id_wr    = ctrl.if_id_wr;
  assign id_ex_wr    = ctrl.id_ex_wr;
  assign if_id_flush = ctrl.if_id_flush;
  assign id_ex_flush = ctrl.id_ex_flush;
  assign ex_mem_wr   = rst;
  assign mem_wb_wr   = rst;

  // Wrong-path stalls under a taken branch are not real stall cycles.
  always_comb begin
    stall_count_d = stall_count_q;
    if (stall && !ex_branch_taken && (stall_count_q != {CNT_W{1'b1}})) begin
      stall_count_d = stall_count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_count_q <= '0;
    end else begin
      stall_count_q <= stall_count_d;
    end
  end

  assign stall_count = stall_count_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed scoreboard bench: stimulus pushes hand-computed expectations, a negedge monitor pops and compares.
// A second instance with a 4-bit counter checks saturation alongside the default one.
module tb_pipeline_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] id_rs, id_rt, ex_rd;
  logic       id_uses_rs, id_uses_rt, id_uses_hilo, id_jump;
  logic       ex_mem_read, ex_branch_taken, ex_md_start, ex_md_is_div;

  logic        pc_wr, if_id_wr, id_ex_wr, ex_mem_wr, mem_wb_wr, if_id_flush, id_ex_flush;
  logic        md_busy, md_done, md_err;
  logic [15:0] stall_count;

  logic        s_pc_wr, s_if_id_wr, s_id_ex_wr, s_ex_mem_wr, s_mem_wb_wr, s_if_id_flush, s_id_ex_flush;
  logic        s_md_busy, s_md_done, s_md_err;
  logic [3:0]  s_stall_count;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.MUL_CYCLES(4), .DIV_CYCLES(32), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs),
    .id_uses_rt(id_uses_rt), .id_uses_hilo(id_uses_hilo), .id_jump(id_jump),
    .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .ex_branch_taken(ex_branch_taken),
    .ex_md_start(ex_md_start), .ex_md_is_div(ex_md_is_div),
    .pc_wr(pc_wr), .if_id_wr(if_id_wr), .id_ex_wr(id_ex_wr), .ex_mem_wr(ex_mem_wr),
    .mem_wb_wr(mem_wb_wr), .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
    .md_busy(md_busy), .md_done(md_done), .md_err(md_err), .stall_count(stall_count)
  );

  pipeline_hazard_ctrl #(.MUL_CYCLES(4), .DIV_CYCLES(32), .CNT_W(4)) dut_sat (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs),
    .id_uses_rt(id_uses_rt), .id_uses_hilo(id_uses_hilo), .id_jump(id_jump),
    .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .ex_branch_taken(ex_branch_taken),
    .ex_md_start(ex_md_start), .ex_md_is_div(ex_md_is_div),
    .pc_wr(s_pc_wr), .if_id_wr(s_if_id_wr), .id_ex_wr(s_id_ex_wr), .ex_mem_wr(s_ex_mem_wr),
    .mem_wb_wr(s_mem_wb_wr), .if_id_flush(s_if_id_flush), .id_ex_flush(s_id_ex_flush),
    .md_busy(s_md_busy), .md_done(s_md_done), .md_err(s_md_err), .stall_count(s_stall_count)
  );

  // {pc_wr, if_id_wr, id_ex_wr, ex_mem_wr, mem_wb_wr, if_id_flush, id_ex_flush}
  localparam logic [6:0] K_RST   = 7'b00000_11;
  localparam logic [6:0] K_NORM  = 7'b11111_00;
  localparam logic [6:0] K_STALL = 7'b00111_01;
  localparam logic [6:0] K_BR    = 7'b11111_11;
  localparam logic [6:0] K_JMP   = 7'b11111_10;

  logic [9:0]  exp_flags_q[$];
  logic [15:0] exp_cnt_q[$];
  logic [3:0]  exp_sat_q[$];
  string       exp_tag_q[$];

  int compared   = 0;
  int mismatched = 0;

  task automatic idle_inputs();
    id_rs = 5'd0; id_rt = 5'd0; ex_rd = 5'd0;
    id_uses_rs = 1'b0; id_uses_rt = 1'b0; id_uses_hilo = 1'b0; id_jump = 1'b0;
    ex_mem_read = 1'b0; ex_branch_taken = 1'b0; ex_md_start = 1'b0; ex_md_is_div = 1'b0;
  endtask

  task automatic load_use_rs8();
    ex_mem_read = 1'b1; ex_rd = 5'd8; id_uses_rs = 1'b1; id_rs = 5'd8;
  endtask

  // Inputs for the cycle are already driven; record what the outputs must be, then advance.
  task automatic expect_cycle(input string tag, input logic [6:0] k, input logic busy,
                              input logic done, input logic err, input int sc);
    exp_flags_q.push_back({k, busy, done, err});
    exp_cnt_q.push_back(sc[15:0]);
    exp_sat_q.push_back((sc > 15) ? 4'd15 : sc[3:0]);
    exp_tag_q.push_back(tag);
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (exp_flags_q.size() > 0) begin
      logic [9:0]  ef, af, sf;
      logic [15:0] ec;
      logic [3:0]  es;
      string       t;
      ef = exp_flags_q.pop_front();
      ec = exp_cnt_q.pop_front();
      es = exp_sat_q.pop_front();
      t  = exp_tag_q.pop_front();
      af = {pc_wr, if_id_wr, id_ex_wr, ex_mem_wr, mem_wb_wr, if_id_flush, id_ex_flush,
            md_busy, md_done, md_err};
      sf = {s_pc_wr, s_if_id_wr, s_id_ex_wr, s_ex_mem_wr, s_mem_wb_wr, s_if_id_flush, s_id_ex_flush,
            s_md_busy, s_md_done, s_md_err};
      compared++;
      if (af !== ef || sf !== ef || stall_count !== ec || s_stall_count !== es) begin
        mismatched++;
        $display("FAIL %s @%0t: got flags=%b sat_flags=%b cnt=%0d sat_cnt=%0d, want flags=%b cnt=%0d sat_cnt=%0d",
                 t, $time, af, sf, stall_count, s_stall_count, ef, ec, es);
      end
    end
  end

  initial begin
    int sc;
    rst = 1'b0;
    idle_inputs();
    @(posedge clk);
    #1;

    expect_cycle("reset0", K_RST, 0, 0, 0, 0);
    expect_cycle("reset1", K_RST, 0, 0, 0, 0);
    load_use_rs8();
    expect_cycle("reset_with_hazard", K_RST, 0, 0, 0, 0);

    rst = 1'b1;
    idle_inputs();
    expect_cycle("run_idle", K_NORM, 0, 0, 0, 0);
    load_use_rs8();
    expect_cycle("load_use_rs", K_STALL, 0, 0, 0, 0);
    idle_inputs();
    expect_cycle("after_load_use", K_NORM, 0, 0, 0, 1);
    ex_mem_read = 1'b1; ex_rd = 5'd0; id_uses_rs = 1'b1; id_rs = 5'd0;
    expect_cycle("zero_reg", K_NORM, 0, 0, 0, 1);
    idle_inputs();
    ex_mem_read = 1'b1; ex_rd = 5'd9; id_rt = 5'd9; id_uses_rt = 1'b0;
    expect_cycle("rt_unused", K_NORM, 0, 0, 0, 1);
    id_uses_rt = 1'b1;
    expect_cycle("load_use_rt", K_STALL, 0, 0, 0, 1);
    idle_inputs();
    load_use_rs8(); ex_branch_taken = 1'b1;
    expect_cycle("branch_beats_stall", K_BR, 0, 0, 0, 2);
    idle_inputs();
    expect_cycle("after_branch", K_NORM, 0, 0, 0, 2);
    id_jump = 1'b1;
    expect_cycle("jump", K_JMP, 0, 0, 0, 2);
    load_use_rs8();
    expect_cycle("jump_held_by_stall", K_STALL, 0, 0, 0, 2);
    idle_inputs();
    expect_cycle("idle_sc3", K_NORM, 0, 0, 0, 3);

    // Divide with a HI/LO consumer waiting in ID from cycle 1.
    ex_md_start = 1'b1; ex_md_is_div = 1'b1;
    expect_cycle("div_issue", K_NORM, 0, 0, 0, 3);
    idle_inputs();
    id_uses_hilo = 1'b1;
    for (int k = 1; k <= 32; k++) begin
      expect_cycle("div_busy", K_STALL, 1, (k == 32), 0, 3 + k - 1);
    end
    expect_cycle("div_release", K_NORM, 0, 0, 0, 35);
    id_uses_hilo = 1'b0;
    expect_cycle("div_idle", K_NORM, 0, 0, 0, 35);

    ex_md_start = 1'b1;
    expect_cycle("mul_issue", K_NORM, 0, 0, 0, 35);
    ex_md_start = 1'b0; id_uses_hilo = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      expect_cycle("mul_busy", K_STALL, 1, (k == 4), 0, 35 + k - 1);
    end
    expect_cycle("mul_release", K_NORM, 0, 0, 0, 39);
    id_uses_hilo = 1'b0;

    // Second issue on busy cycle 3 must not reload the count.
    ex_md_start = 1'b1;
    expect_cycle("mis_issue", K_NORM, 0, 0, 0, 39);
    ex_md_start = 1'b0;
    expect_cycle("mis_c1", K_NORM, 1, 0, 0, 39);
    expect_cycle("mis_c2", K_NORM, 1, 0, 0, 39);
    ex_md_start = 1'b1;
    expect_cycle("mis_c3_restart", K_NORM, 1, 0, 0, 39);
    ex_md_start = 1'b0;
    expect_cycle("mis_c4_done", K_NORM, 1, 1, 1, 39);
    expect_cycle("mis_c5_idle", K_NORM, 0, 0, 1, 39);

    ex_md_start = 1'b1;
    expect_cycle("rst_mid_issue", K_NORM, 0, 0, 1, 39);
    ex_md_start = 1'b0;
    expect_cycle("rst_mid_busy", K_NORM, 1, 0, 1, 39);
    rst = 1'b0;
    expect_cycle("rst_mid_assert", K_RST, 0, 0, 1, 39);
    rst = 1'b1;
    expect_cycle("rst_mid_after", K_NORM, 0, 0, 0, 0);
    expect_cycle("rst_mid_no_done", K_NORM, 0, 0, 0, 0);

    load_use_rs8();
    for (int k = 0; k < 20; k++) begin
      expect_cycle("sat_hold", K_STALL, 0, 0, 0, k);
    end
    idle_inputs();
    expect_cycle("sat_final", K_NORM, 0, 0, 0, 20);

    for (int w = 0; w < 5 && exp_flags_q.size() > 0; w++) @(posedge clk);
    if (exp_flags_q.size() > 0) begin
      compared++;
      mismatched++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", exp_flags_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
